vga_stream_out: RTL and testbench

Parametrised VGA scan-out engine for the pong system: generates the raster timing and drains a ready/valid pixel stream onto the VGA DAC conduit. It is the successor to the fixed 640x480, 4-bit-per-channel conduit. Resolution, porches, sync polarity and colour depth are parameters. It adds start-of-frame alignment checking with automatic resync, underflow reporting and a frame-start strobe for the game logic.

---
 rtl/vga_stream_out.sv | 140 ++++++++++++++
 tb/tb_vga_stream_out.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vga_stream_out.sv
// VGA raster timing generator that drains a ready/valid pixel stream onto the DAC conduit.
// Define VGA_TEST_PATTERN_EN to build in the 8-bar colour test pattern (test_pattern_sel).
module vga_stream_out #(
   parameter int   COLOR_W  = 4,
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset,
   input  logic [3*COLOR_W-1:0] pix_data,
   input  logic                 pix_valid,
   input  logic                 pix_sop,
   output logic                 pix_ready,
   input  logic                 test_pattern_sel,
   output logic                 vga_conduit_CLK,
   output logic                 vga_conduit_HS,
   output logic                 vga_conduit_VS,
   output logic                 vga_conduit_BLANK,
   output logic                 vga_conduit_SYNC,
   output logic [COLOR_W-1:0]   vga_conduit_R,
   output logic [COLOR_W-1:0]   vga_conduit_G,
   output logic [COLOR_W-1:0]   vga_conduit_B,
   output logic                 frame_start,
   output logic                 underflow
);

   localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW     = $clog2(H_TOT);
   localparam int VW     = $clog2(V_TOT);
   localparam int HS_BEG = H_ACTIVE + H_FP;
   localparam int HS_END = HS_BEG + H_SYNC;
   localparam int VS_BEG = V_ACTIVE + V_FP;
   localparam int VS_END = VS_BEG + V_SYNC;

   typedef enum logic [1:0] {HUNT, WAIT_FRAME, SYNCED} state_t;

   state_t               state, state_nxt;
   logic [HW-1:0]        h_cnt;
   logic [VW-1:0]        v_cnt;
   logic                 at_origin, active, eff_synced, show, starve, tp;
   logic [3*COLOR_W-1:0] pix_nxt;

   assign vga_conduit_CLK  = clk_clk;
   assign vga_conduit_SYNC = 1'b0;

   assign at_origin  = (h_cnt == '0) && (v_cnt == '0);
   assign active     = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
   // WAIT_FRAME behaves as SYNCED at the origin so the first pixel is not lost
   assign eff_synced = (state == SYNCED) || ((state == WAIT_FRAME) && at_origin);

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
   logic [2:0]           bar;
   logic [3*COLOR_W-1:0] bar_rgb;

   assign tp = test_pattern_sel;

   always_comb begin
      bar     = (int'(h_cnt) >= 8 * BAR_W) ? 3'd7 : 3'(int'(h_cnt) / BAR_W);
      bar_rgb = {{COLOR_W{~bar[1]}}, {COLOR_W{~bar[2]}}, {COLOR_W{~bar[0]}}};
   end
`else
   logic sel_unused;

   assign tp         = 1'b0;
   assign sel_unused = test_pattern_sel;
`endif

   always_ff @(posedge clk_clk) begin
      if (reset_reset) state <= HUNT;
      else             state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (eff_synced)
         state_nxt = (pix_valid && active && (pix_sop != at_origin)) ? HUNT : SYNCED;
      else if ((state == HUNT) && pix_valid && pix_sop)
         state_nxt = WAIT_FRAME;
      if (tp) state_nxt = HUNT;
   end

   always_comb begin
      pix_ready = 1'b0;
      if (eff_synced)         pix_ready = active;
      else if (state == HUNT) pix_ready = !(pix_valid && pix_sop);
      if (tp)                 pix_ready = 1'b1;
      if (reset_reset)        pix_ready = 1'b0;
      show   = eff_synced && active && pix_valid && (pix_sop == at_origin) && !tp;
      starve = eff_synced && active && !pix_valid && !tp;
   end

   always_comb begin
      pix_nxt = '0;
      if (show) pix_nxt = pix_data;
`ifdef VGA_TEST_PATTERN_EN
      if (tp && active) pix_nxt = bar_rgb;
`endif
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         h_cnt             <= '0;
         v_cnt             <= '0;
         vga_conduit_HS    <= ~HS_POL;
         vga_conduit_VS    <= ~VS_POL;
         vga_conduit_BLANK <= 1'b0;
         vga_conduit_R     <= '0;
         vga_conduit_G     <= '0;
         vga_conduit_B     <= '0;
         frame_start       <= 1'b0;
         underflow         <= 1'b0;
      end else begin
         if (int'(h_cnt) == H_TOT - 1) begin
            h_cnt <= '0;
            v_cnt <= (int'(v_cnt) == V_TOT - 1) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
         vga_conduit_HS    <= ((int'(h_cnt) >= HS_BEG) && (int'(h_cnt) < HS_END)) ? HS_POL : ~HS_POL;
         vga_conduit_VS    <= ((int'(v_cnt) >= VS_BEG) && (int'(v_cnt) < VS_END)) ? VS_POL : ~VS_POL;
         vga_conduit_BLANK <= active;
         vga_conduit_R     <= pix_nxt[3*COLOR_W-1 -: COLOR_W];
         vga_conduit_G     <= pix_nxt[2*COLOR_W-1 -: COLOR_W];
         vga_conduit_B     <= pix_nxt[COLOR_W-1:0];
         frame_start       <= (h_cnt == '0) && (int'(v_cnt) == V_ACTIVE);
         underflow         <= starve;
      end
   end

endmodule

// File: tb/tb_vga_stream_out.sv
// Scoreboard bench for vga_stream_out on a 14x7 raster (8x4 active).
module tb_vga_stream_out;

   localparam int M_WAIT = 0, M_ALIGN = 1, M_GAP = 2, M_DROP = 3,
                  M_OFFSET = 4, M_POSTRST = 5, M_BARS = 6;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        blank;
      logic [11:0] rgb;
      logic        fs;
      logic        uf;
   } out_t;

   logic        clk = 1'b0;
   logic        reset_reset = 1'b1;
   logic [11:0] pix_data = '0;
   logic        pix_valid = 1'b0;
   logic        pix_sop = 1'b0;
   logic        pix_ready;
   logic        test_pattern_sel = 1'b0;
   logic        vclk, hs, vs, blank, sync, frame_start, underflow;
   logic [3:0]  r, g, b;

   out_t q[$];
   int   checks = 0;
   int   passes = 0;
   int   idx = 0;
   bit   fire = 1'b0;

   always #5 clk = ~clk;

   vga_stream_out #(
      .COLOR_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut (
      .clk_clk(clk), .reset_reset(reset_reset),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_sop(pix_sop), .pix_ready(pix_ready),
      .test_pattern_sel(test_pattern_sel),
      .vga_conduit_CLK(vclk), .vga_conduit_HS(hs), .vga_conduit_VS(vs),
      .vga_conduit_BLANK(blank), .vga_conduit_SYNC(sync),
      .vga_conduit_R(r), .vga_conduit_G(g), .vga_conduit_B(b),
      .frame_start(frame_start), .underflow(underflow)
   );

   function automatic out_t pos_out(input int h, input int v, input logic [11:0] rgb, input bit uf);
      out_t o;
      o.hs    = !(h >= 10 && h < 12);
      o.vs    = !(v == 5);
      o.blank = (h < 8) && (v < 4);
      o.rgb   = rgb;
      o.fs    = (h == 0) && (v == 4);
      o.uf    = uf;
      return o;
   endfunction

   function automatic out_t rst_out();
      out_t o = '0;
      o.hs = 1'b1;
      o.vs = 1'b1;
      return o;
   endfunction

   // One pixel clock: drive the stream beat, check pix_ready, queue the expected conduit word.
   task automatic step(input bit rst, input bit gap, input bit force0, input bit sel,
                       input out_t e, input bit rdy_exp);
      @(negedge clk);
      if (fire) idx = (idx + 1) % 32;
      if (force0) idx = 0;
      reset_reset      = rst;
      pix_valid        = !gap;
      pix_data         = 12'(idx);
      pix_sop          = (idx == 0);
      test_pattern_sel = sel;
      #1;
      fire = pix_valid && pix_ready;
      checks++;
      if (pix_ready === rdy_exp) passes++;
      else $display("FAIL pix_ready at %0t: got %b want %b", $time, pix_ready, rdy_exp);
      q.push_back(e);
   endtask

   task automatic run_frame(input int mode, input int stop_at);
      logic [11:0] bars [8];
      bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
      for (int k = 0; k < stop_at; k++) begin
         int          h   = k % 14;
         int          v   = k / 14;
         bit          act = (h < 8) && (v < 4);
         int          p   = v * 8 + h;
         logic [11:0] px  = '0;
         bit          uf = 0, gap = 0, f0 = 0, sel = 0, rdy = act;
         case (mode)
            M_WAIT:    rdy = 1'b0;
            M_ALIGN:   if (act) px = 12'(p);
            M_GAP:     if (act) begin
                          if (p < 11)       px = 12'(p);
                          else if (p == 11) begin gap = 1; uf = 1; end
                          else              px = 12'(p - 1);
                       end
            M_DROP:    rdy = (k == 0);
            M_OFFSET:  begin
                          if (k == 30) f0 = 1;
                          if (k < 30 && act) px = 12'(p);
                          rdy = (k < 30) ? act : (k < 62);
                       end
            M_POSTRST: rdy = (k < 11);
            M_BARS:    begin sel = 1; rdy = 1; if (act) px = bars[h]; end
            default:   ;
         endcase
         step(1'b0, gap, f0, sel, pos_out(h, v, px, uf), rdy);
      end
   endtask

   initial begin : monitor
      out_t e, got;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e   = q.pop_front();
            got = {hs, vs, blank, r, g, b, frame_start, underflow};
            checks++;
            if (got === e) passes++;
            else $display("FAIL conduit at %0t: got hs%b vs%b bl%b rgb%h fs%b uf%b want hs%b vs%b bl%b rgb%h fs%b uf%b",
                          $time, got.hs, got.vs, got.blank, got.rgb, got.fs, got.uf,
                          e.hs, e.vs, e.blank, e.rgb, e.fs, e.uf);
         end
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, rst_out(), 1'b0);
      run_frame(M_WAIT, 98);     // sop seen in HUNT, wait for origin
      run_frame(M_ALIGN, 98);
      run_frame(M_ALIGN, 98);
      run_frame(M_GAP, 98);      // starved pixel at (3,1)
      run_frame(M_DROP, 98);     // stale beat at origin -> relock
      run_frame(M_ALIGN, 98);
      run_frame(M_OFFSET, 98);   // stray sop at (2,2)
      run_frame(M_ALIGN, 98);
      run_frame(M_ALIGN, 33);    // reset pulse at (5,2)
      step(1'b1, 1'b0, 1'b0, 1'b0, rst_out(), 1'b0);
      run_frame(M_POSTRST, 98);
      run_frame(M_ALIGN, 98);
`ifdef VGA_TEST_PATTERN_EN
      run_frame(M_BARS, 98);
`endif
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (q.size() == 0) passes++;
      else $display("FAIL scoreboard drain: got %0d entries left want 0", q.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
